// File: rtl/instr_fetch_queue_pkg.sv
// Shared widths and entry type for the fetch->decode prefetch queue.
package instr_fetch_queue_pkg;
   localparam int WORD      = 64;
   localparam int INSTR_LEN = 32;
   localparam int FQ_DEPTH  = 4;

   typedef struct packed {
      logic [INSTR_LEN-1:0] instr;
      logic [WORD-1:0]      pc;
   } fq_entry_t;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// One valid/ready channel carrying an {instruction, PC} pair.
interface instr_fetch_queue_if;
   import instr_fetch_queue_pkg::*;

   logic                 valid;
   logic                 ready;
   logic [INSTR_LEN-1:0] instr;
   logic [WORD-1:0]      pc;

   modport master (output valid, output instr, output pc, input ready);
   modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/instr_fetch_queue.sv
// Circular prefetch buffer between fetch and decode; a taken branch flushes
// every queued entry. Full/empty come from count, so pointers need no wrap bit.
module instr_fetch_queue
   import instr_fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_queue_if.slave  enq,
   instr_fetch_queue_if.master deq,
   input  logic                flush,
   output logic [PTR_W:0]      count
);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [INSTR_LEN-1:0] instr_mem [DEPTH];
   logic [WORD-1:0]      pc_mem    [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 push;
   logic                 pop;

   // in_ready ignores out_ready on purpose: a full queue never takes a push
   // in the same cycle it pops.
   assign enq.ready = (count != CNT_FULL);
   assign deq.valid = (count != '0);
   assign push      = enq.valid && enq.ready;
   assign pop       = deq.valid && deq.ready;
   assign deq.instr = deq.valid ? instr_mem[rd_ptr] : '0;
   assign deq.pc    = deq.valid ? pc_mem[rd_ptr]    : '0;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         instr_mem[wr_ptr] <= enq.instr;
         pc_mem[wr_ptr]    <= enq.pc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_queue;
   import instr_fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic [PTR_W:0]   count;
   bit               chk_en = 1'b0;
   int               n_chk = 0;
   int               n_err = 0;
   fq_entry_t        mq[$];

   instr_fetch_queue_if enq();
   instr_fetch_queue_if deq();

   instr_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .enq   (enq),
      .deq   (deq),
      .flush (flush),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: an ordered list of entries, updated from the rules.
   always @(posedge clk or negedge reset) begin : model
      bit do_push, do_pop;
      fq_entry_t e;
      if (!reset) begin
         mq.delete();
      end else if (flush) begin
         mq.delete();
      end else begin
         do_pop  = (mq.size() != 0) && deq.ready;
         do_push = enq.valid && (mq.size() < DEPTH);
         e.instr = enq.instr;
         e.pc    = enq.pc;
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(e);
      end
   end

   always @(negedge clk) begin : compare
      if (chk_en) begin
         chk("count",     64'(count),     64'(mq.size()));
         chk("out_valid", 64'(deq.valid), 64'(mq.size() != 0));
         chk("in_ready",  64'(enq.ready), 64'(mq.size() != DEPTH));
         chk("out_instr", 64'(deq.instr), (mq.size() != 0) ? 64'(mq[0].instr) : 64'd0);
         chk("out_pc",    deq.pc,         (mq.size() != 0) ? mq[0].pc : 64'd0);
      end
   end

   task automatic drive(input bit iv, input logic [31:0] ins, input logic [63:0] p,
                        input bit ordy, input bit fl);
      enq.valid = iv;
      enq.instr = ins;
      enq.pc    = p;
      deq.ready = ordy;
      flush     = fl;
      @(negedge clk);
   endtask

   logic [31:0] fill_i [5] = '{32'h8B020020, 32'hCB020020, 32'hAA020020, 32'h8A020020, 32'hF8000020};
   logic [63:0] fill_p [5] = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd16};
   logic [31:0] got_i [10];
   logic [63:0] got_p [10];

   initial begin
      enq.valid = 1'b0;
      enq.instr = '0;
      enq.pc    = '0;
      deq.ready = 1'b0;

      // Power-up reset: outputs settle with no clock edge.
      #1 reset = 1'b0;
      #1;
      chk("rst0_count",     64'(count),     64'd0);
      chk("rst0_out_valid", 64'(deq.valid), 64'd0);
      chk("rst0_in_ready",  64'(enq.ready), 64'd1);
      chk("rst0_out_instr", 64'(deq.instr), 64'd0);
      chk("rst0_out_pc",    deq.pc,         64'd0);
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b1;
      chk_en = 1'b1;

      // Mid-operation asynchronous reset
      for (int i = 0; i < 3; i++) drive(1, 32'h11000000 + 32'(i), 64'h100 + 64'(4*i), 0, 0);
      chk("pre_rst_count", 64'(count), 64'd3);
      enq.valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_count",     64'(count),     64'd0);
      chk("mid_rst_out_valid", 64'(deq.valid), 64'd0);
      chk("mid_rst_in_ready",  64'(enq.ready), 64'd1);
      chk("mid_rst_out_instr", 64'(deq.instr), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Fill and overflow, then drain in order
      for (int i = 0; i < 5; i++) drive(1, fill_i[i], fill_p[i], 0, 0);
      chk("fill_count",     64'(count),     64'd4);
      chk("fill_in_ready",  64'(enq.ready), 64'd0);
      chk("fill_model_sz",  64'(mq.size()), 64'd4);
      chk("fill_model_tail", 64'(mq[3].instr), 64'h8A020020);
      for (int i = 0; i < 4; i++) begin
         chk("drain_instr", 64'(deq.instr), 64'(fill_i[i]));
         chk("drain_pc",    deq.pc,         fill_p[i]);
         drive(0, '0, '0, 1, 0);
      end
      chk("drain_count", 64'(count), 64'd0);

      // Simultaneous push and pop at count 2
      drive(1, 32'h10000001, 64'h200, 0, 0);
      drive(1, 32'h10000002, 64'h204, 0, 0);
      drive(1, 32'h10000003, 64'h208, 1, 0);
      chk("pp_count", 64'(count),     64'd2);
      chk("pp_head",  64'(deq.instr), 64'h10000002);
      drive(0, '0, '0, 1, 0);
      chk("pp_next",  64'(deq.instr), 64'h10000003);
      chk("pp_next_pc", deq.pc,       64'h208);
      drive(0, '0, '0, 1, 0);
      chk("pp_empty", 64'(count), 64'd0);

      // Flush beats a concurrent push and pop
      for (int i = 0; i < 3; i++) drive(1, 32'h20000000 + 32'(i), 64'h300 + 64'(4*i), 0, 0);
      chk("fl_pre_count", 64'(count), 64'd3);
      drive(1, 32'hDEAD0000, 64'h3F0, 1, 1);
      chk("fl_count",     64'(count),     64'd0);
      chk("fl_out_valid", 64'(deq.valid), 64'd0);
      chk("fl_in_ready",  64'(enq.ready), 64'd1);
      drive(1, 32'h50000001, 64'h400, 0, 0);
      chk("fl_after_count", 64'(count),     64'd1);
      chk("fl_after_head",  64'(deq.instr), 64'h50000001);

      // Full plus pop: pop accepted, push rejected, push taken next cycle
      for (int i = 2; i < 5; i++) drive(1, 32'h50000000 + 32'(i), 64'h400 + 64'(4*(i-1)), 0, 0);
      chk("fp_full", 64'(count), 64'd4);
      drive(1, 32'h60000000, 64'h500, 1, 0);
      chk("fp_count", 64'(count),     64'd3);
      chk("fp_head",  64'(deq.instr), 64'h50000002);
      drive(1, 32'h60000000, 64'h500, 0, 0);
      chk("fp_refill", 64'(count), 64'd4);
      chk("fp_model_tail", 64'(mq[3].instr), 64'h60000000);
      drive(0, '0, '0, 0, 1);

      // Wrap-around stream with out_ready toggling every cycle
      begin
         int  k = 0, n_got = 0, cyc = 0;
         bit  ordy = 1'b0, acc;
         while (n_got < 10 && cyc < 80) begin
            ordy = ~ordy;
            if (deq.valid && ordy) begin
               got_i[n_got] = deq.instr;
               got_p[n_got] = deq.pc;
               n_got++;
            end
            acc = (k < 10) && enq.ready;
            drive(k < 10, 32'h8B000000 | 32'(k), 64'(4*k), ordy, 0);
            if (acc) k++;
            cyc++;
         end
         chk("wrap_n", 64'(n_got), 64'd10);
         for (int i = 0; i < n_got; i++) begin
            chk("wrap_instr", 64'(got_i[i]), 64'(32'h8B000000 | 32'(i)));
            chk("wrap_pc",    got_p[i],      64'(4*i));
         end
      end
      drive(0, '0, '0, 0, 1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom},
               1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
      drive(0, '0, '0, 0, 0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
